// File: rtl/hazard_unit_mc.sv
// Hazard/interlock unit for the 5-stage MIPS pipeline (F/D/E/M/W).
// Produces stage stalls, bubbles and forwarding selects. Also runs the
// handshake with the multi-cycle divider: start pulse, cancel pulse and
// a sticky timeout flag. An exception flush overrides every stall.
module hazard_unit_mc #(
    parameter int             RW      = 5,
    parameter int             ACW     = 5,
    parameter logic [ACW-1:0] DIV_OP  = 5'b11010,
    parameter logic [ACW-1:0] DIVU_OP = 5'b11011,
    parameter int             DIV_TMO = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [RW-1:0]  rsD,
    input  logic [RW-1:0]  rtD,
    input  logic [RW-1:0]  rsE,
    input  logic [RW-1:0]  rtE,
    input  logic [RW-1:0]  writeregE,
    input  logic [RW-1:0]  writeregM,
    input  logic [RW-1:0]  writeregW,
    input  logic           regwriteE,
    input  logic           regwriteM,
    input  logic           regwriteW,
    input  logic           memtoregE,
    input  logic           memtoregM,
    input  logic           branchD,
    input  logic           jumpD,
    input  logic           balD,
    input  logic [1:0]     hilo_weE,
    input  logic [1:0]     hilo_weM,
    input  logic [1:0]     hilo_weW,
    input  logic [ACW-1:0] alucontrolE,
    input  logic           div_ready,
    input  logic           excp_flush,
    output logic           div_start,
    output logic           div_cancel,
    output logic           div_err,
    output logic           stallF,
    output logic           stallD,
    output logic           stallE,
    output logic           flushD,
    output logic           flushE,
    output logic           flushM,
    output logic [1:0]     forwardaE,
    output logic [1:0]     forwardbE,
    output logic           forwardaD,
    output logic           forwardbD,
    output logic [1:0]     forwardhiloE
);

    // Counter only has to reach DIV_TMO-1, the last BUSY cycle before abort.
    localparam int             CW       = $clog2(DIV_TMO);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV_TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic           r_div_start;
    logic           r_div_cancel;
    logic           r_div_err;

    logic           w_cnt_clr;
    logic           w_cnt_inc;
    logic           w_abort;
    logic           w_tmo;

    logic           w_divE;
    logic           w_lwstall;
    logic           w_branchstall;
    logic           w_divstall;
    logic           w_ctrl_bubble;

    logic [1:0]     w_fwdaE;
    logic [1:0]     w_fwdbE;
    logic           w_fwdaD;
    logic           w_fwdbD;
    logic [1:0]     w_fwdhilo;

    // E-operand select: the younger producer (M) wins over W; $0 is hard-wired.
    function automatic logic [1:0] fwd_e_sel(
        input logic [RW-1:0] src,
        input logic [RW-1:0] wr_m,
        input logic          we_m,
        input logic [RW-1:0] wr_w,
        input logic          we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (we_m && (src == wr_m)) begin
                sel = 2'b10;
            end else if (we_w && (src == wr_w)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    // Branch-compare operands in D can only take the M-stage ALU result.
    function automatic logic fwd_d_sel(
        input logic [RW-1:0] src,
        input logic [RW-1:0] wr_m,
        input logic          we_m
    );
        return (src != '0) && we_m && (src == wr_m);
    endfunction

    // Forwarding selects for E operands, D branch operands and HI/LO.
    always_comb begin
        w_fwdaE = fwd_e_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
        w_fwdbE = fwd_e_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
        w_fwdaD = fwd_d_sel(rsD, writeregM, regwriteM);
        w_fwdbD = fwd_d_sel(rtD, writeregM, regwriteM);
        if ((hilo_weE == 2'b00) && (hilo_weM != 2'b00)) begin
            w_fwdhilo = 2'b01;
        end else if (hilo_weW != 2'b00) begin
            w_fwdhilo = 2'b10;
        end else begin
            w_fwdhilo = 2'b00;
        end
    end

    // Interlock terms: load-use, branch operand not yet available, divider busy.
    always_comb begin
        w_lwstall     = memtoregE && (writeregE != '0) &&
                        ((writeregE == rsD) || (writeregE == rtD));
        w_branchstall = branchD &&
                        ((regwriteE && (writeregE != '0) &&
                          ((writeregE == rsD) || (writeregE == rtD))) ||
                         (memtoregM && (writeregM != '0) &&
                          ((writeregM == rsD) || (writeregM == rtD))));
        w_divE        = (alucontrolE == DIV_OP) || (alucontrolE == DIVU_OP);
        // DONE is deliberately absent so E advances on the cycle the result is taken.
        w_divstall    = ((r_state == ST_IDLE) && w_divE) ||
                        (r_state == ST_START) ||
                        ((r_state == ST_BUSY) && !div_ready);
        w_ctrl_bubble = w_lwstall || w_branchstall || jumpD || (branchD && !balD);
    end

    // Stage control outputs; exception flush beats every stall, reset silences all.
    always_comb begin
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushM       = 1'b0;
        forwardaE    = 2'b00;
        forwardbE    = 2'b00;
        forwardaD    = 1'b0;
        forwardbD    = 1'b0;
        forwardhiloE = 2'b00;
        if (!rst) begin
            if (excp_flush) begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
            end else begin
                stallF = w_lwstall || w_branchstall || w_divstall;
                stallD = w_lwstall || w_branchstall || w_divstall;
                stallE = w_divstall;
                // A held E stage must keep its instruction, so no bubble then.
                flushE = w_ctrl_bubble && !w_divstall;
            end
            forwardaE    = w_fwdaE;
            forwardbE    = w_fwdbE;
            forwardaD    = w_fwdaD;
            forwardbD    = w_fwdbD;
            forwardhiloE = w_fwdhilo;
        end
    end

    // Divider handshake next-state: cancel beats result, result beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_abort     = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_divE && !excp_flush) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (excp_flush) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (excp_flush) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (div_ready) begin
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                    w_tmo       = 1'b1;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Divider handshake registers; start/cancel are one-cycle registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_div_start  <= 1'b0;
            r_div_cancel <= 1'b0;
            r_div_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_div_start  <= (w_state_nxt == ST_START);
            r_div_cancel <= w_abort;
            if (w_tmo) begin
                r_div_err <= 1'b1;
            end
        end
    end

    assign div_start  = r_div_start;
    assign div_cancel = r_div_cancel;
    assign div_err    = r_div_err;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (short and default divider
// timeout) share all inputs; a cycle-level model of the rules checks both
// every cycle, and directed sequences add hand-computed expectations.
module tb_hazard_unit_mc;

    localparam logic [4:0] OP_DIV  = 5'b11010;
    localparam logic [4:0] OP_DIVU = 5'b11011;
    localparam int         TMO_A   = 8;
    localparam int         TMO_B   = 64;

    logic       clk;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jumpD, balD;
    logic [1:0] hilo_weE, hilo_weM, hilo_weW;
    logic [4:0] alucontrolE;
    logic       div_ready, excp_flush;

    logic       div_start, div_cancel, div_err;
    logic       stallF, stallD, stallE, flushD, flushE, flushM;
    logic [1:0] forwardaE, forwardbE, forwardhiloE;
    logic       forwardaD, forwardbD;

    logic       b_div_start, b_div_cancel, b_div_err;
    logic       b_stallF, b_stallD, b_stallE, b_flushD, b_flushE, b_flushM;
    logic [1:0] b_forwardaE, b_forwardbE, b_forwardhiloE;
    logic       b_forwardaD, b_forwardbD;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit_mc #(.DIV_TMO(TMO_A)) u_dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jumpD(jumpD), .balD(balD),
        .hilo_weE(hilo_weE), .hilo_weM(hilo_weM), .hilo_weW(hilo_weW),
        .alucontrolE(alucontrolE), .div_ready(div_ready), .excp_flush(excp_flush),
        .div_start(div_start), .div_cancel(div_cancel), .div_err(div_err),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardhiloE(forwardhiloE)
    );

    hazard_unit_mc #(.DIV_TMO(TMO_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jumpD(jumpD), .balD(balD),
        .hilo_weE(hilo_weE), .hilo_weM(hilo_weM), .hilo_weW(hilo_weW),
        .alucontrolE(alucontrolE), .div_ready(div_ready), .excp_flush(excp_flush),
        .div_start(b_div_start), .div_cancel(b_div_cancel), .div_err(b_div_err),
        .stallF(b_stallF), .stallD(b_stallD), .stallE(b_stallE),
        .flushD(b_flushD), .flushE(b_flushE), .flushM(b_flushM),
        .forwardaE(b_forwardaE), .forwardbE(b_forwardbE),
        .forwardaD(b_forwardaD), .forwardbD(b_forwardbD),
        .forwardhiloE(b_forwardhiloE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Divide progress per instance as an age: -1 none, 0 start cycle,
    // k>=1 the k-th cycle spent waiting for the result.
    int   m_age [2] = '{-1, -1};
    bit   m_done[2] = '{1'b0, 1'b0};
    bit   m_pend[2] = '{1'b0, 1'b0};
    bit   m_err [2] = '{1'b0, 1'b0};
    int   m_tmo [2] = '{TMO_A, TMO_B};
    bit   m_known   = 1'b0;

    function automatic logic is_div();
        return (alucontrolE == OP_DIV) || (alucontrolE == OP_DIVU);
    endfunction

    function automatic logic m_divwait(input int i);
        return (m_age[i] < 0 && !m_done[i] && is_div()) || (m_age[i] == 0) ||
               (m_age[i] >= 1 && !div_ready);
    endfunction

    function automatic logic [1:0] m_fwde(input logic [4:0] r);
        if (rst || r == 5'd0) return 2'b00;
        if (regwriteM && r == writeregM) return 2'b10;
        if (regwriteW && r == writeregW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_fwdd(input logic [4:0] r);
        return !rst && r != 5'd0 && regwriteM && r == writeregM;
    endfunction

    function automatic logic [1:0] m_hilo();
        if (rst) return 2'b00;
        if (hilo_weE == 2'b00 && hilo_weM != 2'b00) return 2'b01;
        if (hilo_weW != 2'b00) return 2'b10;
        return 2'b00;
    endfunction

    // Compare both instances against the model, then advance the model.
    always @(negedge clk) begin : cmp
        logic lw, br, bub, run, dva, dvb;
        run = !rst;
        lw  = memtoregE && writeregE != 5'd0 && (writeregE == rsD || writeregE == rtD);
        br  = branchD && ((regwriteE && writeregE != 5'd0 &&
                           (writeregE == rsD || writeregE == rtD)) ||
                          (memtoregM && writeregM != 5'd0 &&
                           (writeregM == rsD || writeregM == rtD)));
        bub = lw || br || jumpD || (branchD && !balD);
        dva = m_divwait(0);
        dvb = m_divwait(1);
        chk1("stallF", stallF, run && !excp_flush && (lw || br || dva));
        chk1("stallD", stallD, run && !excp_flush && (lw || br || dva));
        chk1("stallE", stallE, run && !excp_flush && dva);
        chk1("flushD", flushD, run && excp_flush);
        chk1("flushE", flushE, run && (excp_flush || (bub && !dva)));
        chk1("flushM", flushM, run && excp_flush);
        chk2("forwardaE", forwardaE, m_fwde(rsE));
        chk2("forwardbE", forwardbE, m_fwde(rtE));
        chk1("forwardaD", forwardaD, m_fwdd(rsD));
        chk1("forwardbD", forwardbD, m_fwdd(rtD));
        chk2("forwardhiloE", forwardhiloE, m_hilo());
        chk1("b_stallF", b_stallF, run && !excp_flush && (lw || br || dvb));
        chk1("b_stallE", b_stallE, run && !excp_flush && dvb);
        chk1("b_flushE", b_flushE, run && (excp_flush || (bub && !dvb)));
        if (m_known) begin
            chk1("div_start", div_start, m_age[0] == 0);
            chk1("div_cancel", div_cancel, m_pend[0]);
            chk1("div_err", div_err, m_err[0]);
            chk1("b_div_start", b_div_start, m_age[1] == 0);
            chk1("b_div_cancel", b_div_cancel, m_pend[1]);
            chk1("b_div_err", b_div_err, m_err[1]);
        end
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_age[i] = -1; m_done[i] = 1'b0; m_pend[i] = 1'b0; m_err[i] = 1'b0;
            end else begin
                m_pend[i] = 1'b0;
                if (m_done[i]) begin
                    m_done[i] = 1'b0;
                end else if (m_age[i] < 0) begin
                    if (is_div() && !excp_flush) m_age[i] = 0;
                end else if (excp_flush) begin
                    m_age[i] = -1; m_pend[i] = 1'b1;
                end else if (m_age[i] >= 1 && div_ready) begin
                    m_age[i] = -1; m_done[i] = 1'b1;
                end else if (m_age[i] == m_tmo[i]) begin
                    m_age[i] = -1; m_pend[i] = 1'b1; m_err[i] = 1'b1;
                end else begin
                    m_age[i] = m_age[i] + 1;
                end
            end
        end
        if (rst) m_known = 1'b1;
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_inputs();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; jumpD = 1'b0; balD = 1'b0;
        hilo_weE = 2'b00; hilo_weM = 2'b00; hilo_weW = 2'b00;
        alucontrolE = 5'd0; div_ready = 1'b0; excp_flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int nstart;
        clear_inputs();
        rst = 1'b1;
        memtoregE = 1'b1; writeregE = 5'd5; rtD = 5'd5;
        regwriteM = 1'b1; writeregM = 5'd8; rsE = 5'd8;
        @(negedge clk);
        chk1("rst_stallF", stallF, 1'b0);
        chk1("rst_flushE", flushE, 1'b0);
        chk2("rst_fwdaE", forwardaE, 2'b00);
        tick();
        @(negedge clk);
        tick();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk1("post_rst_start", div_start, 1'b0);
        chk1("post_rst_cancel", div_cancel, 1'b0);
        chk1("post_rst_err", div_err, 1'b0);
        chk1("post_rst_stallE", stallE, 1'b0);
        tick();

        // forwarding
        regwriteM = 1'b1; regwriteW = 1'b1; writeregM = 5'd8; writeregW = 5'd8; rsE = 5'd8;
        @(negedge clk); chk2("fwd_m_prio", forwardaE, 2'b10); tick();
        writeregM = 5'd3; rtE = 5'd8;
        @(negedge clk); chk2("fwd_w_b", forwardbE, 2'b01); tick();
        writeregM = 5'd0; writeregW = 5'd0; rsE = 5'd0; rtE = 5'd0;
        @(negedge clk); chk2("fwd_r0", forwardaE, 2'b00); tick();
        rsD = 5'd9; writeregM = 5'd9;
        @(negedge clk); chk1("fwd_d_a", forwardaD, 1'b1); chk1("fwd_d_b", forwardbD, 1'b0); tick();
        clear_inputs(); hilo_weM = 2'b10;
        @(negedge clk); chk2("hilo_m", forwardhiloE, 2'b01); tick();
        hilo_weE = 2'b01; hilo_weW = 2'b01;
        @(negedge clk); chk2("hilo_w", forwardhiloE, 2'b10); tick();
        clear_inputs();

        // load-use, branch and jump
        memtoregE = 1'b1; writeregE = 5'd5; rtD = 5'd5;
        @(negedge clk);
        chk1("lu_stallF", stallF, 1'b1); chk1("lu_stallD", stallD, 1'b1);
        chk1("lu_flushE", flushE, 1'b1); chk1("lu_stallE", stallE, 1'b0);
        tick(); clear_inputs();
        @(negedge clk); chk1("lu_release", stallF, 1'b0); tick();
        memtoregE = 1'b1; writeregE = 5'd0; rtD = 5'd0;
        @(negedge clk); chk1("lu_r0", stallD, 1'b0); chk1("lu_r0_flush", flushE, 1'b0); tick();
        clear_inputs();
        branchD = 1'b1; balD = 1'b1; regwriteE = 1'b1; writeregE = 5'd4; rsD = 5'd4;
        @(negedge clk); chk1("br_stallD", stallD, 1'b1); chk1("br_flushE", flushE, 1'b1); tick();
        clear_inputs(); jumpD = 1'b1;
        @(negedge clk); chk1("j_flushE", flushE, 1'b1); chk1("j_stallF", stallF, 1'b0); tick();
        clear_inputs();

        // divide, result 10 cycles after the start pulse (default-timeout instance)
        nstart = 0;
        alucontrolE = OP_DIV;
        for (int c = 0; c < 14; c++) begin
            if (c == 11) div_ready = 1'b1;
            if (c == 12) alucontrolE = 5'd0;
            if (c == 13) div_ready = 1'b0;
            @(negedge clk);
            if (b_div_start) nstart++;
            if (c == 0)  begin chk1("rdy_c0_stallE", b_stallE, 1'b1); chk1("rdy_c0_start", b_div_start, 1'b0); end
            if (c == 1)  begin chk1("rdy_c1_start", b_div_start, 1'b1); chk1("rdy_c1_stallE", b_stallE, 1'b1); end
            if (c == 10) chk1("rdy_c10_stallE", b_stallE, 1'b1);
            if (c == 11) chk1("rdy_c11_stallE", b_stallE, 1'b0);
            if (c == 12) begin chk1("rdy_done_stallE", b_stallE, 1'b0); chk1("rdy_done_start", b_div_start, 1'b0); end
            if (c == 13) begin chk1("rdy_cancel", b_div_cancel, 1'b0); chk1("rdy_err", b_div_err, 1'b0); end
            tick();
        end
        chkn("rdy_start_count", nstart, 1);

        rst = 1'b1;
        @(negedge clk); tick();
        rst = 1'b0; clear_inputs();

        // divider never answers: timeout after 8 BUSY cycles (short-timeout instance)
        for (int c = 0; c < 12; c++) begin
            alucontrolE = (c < 10) ? OP_DIVU : 5'd0;
            @(negedge clk);
            if (c == 0)  begin chk1("tmo_c0_stallE", stallE, 1'b1); chk1("tmo_c0_start", div_start, 1'b0); end
            if (c == 1)  chk1("tmo_c1_start", div_start, 1'b1);
            if (c == 9)  begin chk1("tmo_c9_stallE", stallE, 1'b1); chk1("tmo_c9_cancel", div_cancel, 1'b0); end
            if (c == 10) begin
                chk1("tmo_cancel", div_cancel, 1'b1); chk1("tmo_err", div_err, 1'b1);
                chk1("tmo_stallE", stallE, 1'b0); chk1("tmo_stallF", stallF, 1'b0);
            end
            if (c == 11) begin chk1("tmo_cancel_once", div_cancel, 1'b0); chk1("tmo_err_sticky", div_err, 1'b1); end
            tick();
        end

        // reset during BUSY, fresh restart, then exception in BUSY cycle 3
        for (int c = 0; c < 12; c++) begin
            rst = (c == 3);
            alucontrolE = (c == 4 || c >= 10) ? 5'd0 : OP_DIV;
            excp_flush = (c == 9);
            @(negedge clk);
            if (c == 3) begin chk1("rmid_stallE", stallE, 1'b0); chk1("rmid_stallF", stallF, 1'b0); end
            if (c == 4) begin
                chk1("rmid_start", div_start, 1'b0); chk1("rmid_cancel", div_cancel, 1'b0);
                chk1("rmid_err", div_err, 1'b0); chk1("rmid_stallE0", stallE, 1'b0);
            end
            if (c == 5) begin chk1("re_stallE", stallE, 1'b1); chk1("re_start0", div_start, 1'b0); end
            if (c == 6) chk1("re_start", div_start, 1'b1);
            if (c == 9) begin
                chk1("ex_flushD", flushD, 1'b1); chk1("ex_flushE", flushE, 1'b1);
                chk1("ex_flushM", flushM, 1'b1); chk1("ex_stallE", stallE, 1'b0);
                chk1("ex_stallF", stallF, 1'b0);
            end
            if (c == 10) begin
                chk1("ex_cancel", div_cancel, 1'b1); chk1("ex_b_cancel", b_div_cancel, 1'b1);
                chk1("ex_idle_stallE", stallE, 1'b0);
            end
            if (c == 11) begin chk1("ex_cancel_once", div_cancel, 1'b0); chk1("ex_no_start", div_start, 1'b0); end
            tick();
        end
        rst = 1'b0; clear_inputs();

        // cancel and result in the same BUSY cycle: cancel wins
        for (int c = 0; c < 5; c++) begin
            alucontrolE = (c < 3) ? OP_DIV : 5'd0;
            excp_flush = (c == 2);
            div_ready = (c == 2 || c == 3);
            @(negedge clk);
            if (c == 3) chk1("exrdy_cancel", div_cancel, 1'b1);
            if (c == 4) chk1("exrdy_no_start", div_start, 1'b0);
            tick();
        end
        clear_inputs();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
